// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (P), a 2-deep buffer for the
// multicycle unit (M) and an aged debug port (D) share one registered write port.
module wb_arbiter (
  input  logic        clk,
  input  logic        rstn,
  input  logic        p_valid,
  input  logic [4:0]  p_wa,
  input  logic [31:0] p_wd,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic [4:0]  m_wa,
  input  logic [31:0] m_wd,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [4:0]  d_wa,
  input  logic [31:0] d_wd,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic [31:0] busy
);

  // Handshake: a transfer on M or D happens in a cycle where valid && ready are both
  // high at the rising edge; valid must hold until then. P has no ready and is never stalled.

  logic [1:0]  r_count;
  logic        r_head;
  logic        r_tail;
  logic [4:0]  r_fifo_wa [0:1];
  logic [31:0] r_fifo_wd [0:1];
  logic [2:0]  r_d_age;
  logic        r_rf_we;
  logic [4:0]  r_rf_wa;
  logic [31:0] r_rf_wd;

  logic        w_p_eff;
  logic        w_d_urgent;
  logic        w_grant_p;
  logic        w_grant_f;
  logic        w_grant_d;
  logic        w_push;
  logic        w_pop;
  logic [1:0]  w_count_nxt;
  logic [4:0]  w_sel_wa;
  logic [31:0] w_sel_wd;
  logic        w_any_grant;
  logic [1:0]  w_entry_valid;
  logic [31:0] w_busy;

  assign w_p_eff    = p_valid && (p_wa != 5'd0);
  assign w_d_urgent = d_valid && (r_d_age == 3'd4);

  // Aging lets D jump ahead of the buffer only; P always wins.
  assign w_grant_p = w_p_eff;
  assign w_grant_f = !w_p_eff && (r_count != 2'd0) && !w_d_urgent;
  assign w_grant_d = !w_p_eff && !w_grant_f && d_valid;

  assign m_ready = (r_count != 2'd2);
  assign d_ready = w_grant_d && rstn;

  assign w_push = m_valid && m_ready && (m_wa != 5'd0);
  assign w_pop  = w_grant_f;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_sel_wa    = 5'd0;
    w_sel_wd    = 32'd0;
    w_any_grant = 1'b1;
    if (w_grant_p) begin
      w_sel_wa = p_wa;
      w_sel_wd = p_wd;
    end else if (w_grant_f) begin
      w_sel_wa = r_fifo_wa[r_head];
      w_sel_wd = r_fifo_wd[r_head];
    end else if (w_grant_d) begin
      w_sel_wa = d_wa;
      w_sel_wd = d_wd;
    end else begin
      w_any_grant = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count      <= 2'd0;
      r_head       <= 1'b0;
      r_tail       <= 1'b0;
      r_fifo_wa[0] <= 5'd0;
      r_fifo_wa[1] <= 5'd0;
      r_fifo_wd[0] <= 32'd0;
      r_fifo_wd[1] <= 32'd0;
      r_d_age      <= 3'd0;
      r_rf_we      <= 1'b0;
      r_rf_wa      <= 5'd0;
      r_rf_wd      <= 32'd0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push) begin
        r_fifo_wa[r_tail] <= m_wa;
        r_fifo_wd[r_tail] <= m_wd;
        r_tail            <= ~r_tail;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      if (d_valid && !d_ready) begin
        if (r_d_age != 3'd4) begin
          r_d_age <= r_d_age + 3'd1;
        end
      end else begin
        r_d_age <= 3'd0;
      end
      r_rf_we <= w_any_grant && (w_sel_wa != 5'd0);
      if (w_any_grant) begin
        r_rf_wa <= w_sel_wa;
        r_rf_wd <= w_sel_wd;
      end
    end
  end

  assign w_entry_valid[0] = (r_count == 2'd2) || ((r_count == 2'd1) && (r_head == 1'b0));
  assign w_entry_valid[1] = (r_count == 2'd2) || ((r_count == 2'd1) && (r_head == 1'b1));

  always_comb begin
    w_busy = 32'd0;
    for (int i = 1; i < 32; i++) begin
      w_busy[i] = (w_entry_valid[0] && (r_fifo_wa[0] == 5'(i))) ||
                  (w_entry_valid[1] && (r_fifo_wa[1] == 5'(i))) ||
                  (r_rf_we && (r_rf_wa == 5'(i)));
    end
  end

  assign busy  = w_busy;
  assign rf_we = r_rf_we;
  assign rf_wa = r_rf_wa;
  assign rf_wd = r_rf_wd;

endmodule
